serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Sequencer that time-shares one 1-bit adder cell (two mux-style half adders plus a carry OR) across WIDTH-bit operands, LSB first, one bit per clock.
- Holds the operand and result shift registers, the carry flip-flop, a bit counter and a valid/ready handshake on each side.
- Sits between an operand producer and a result consumer as a low-area add/subtract unit.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are 2 to 32.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, do not override.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B; 1: A-B (B inverted, carry-in 1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  final carry; for sub, 1 = no borrow (A>=B unsigned).
- busy  output  1  high in RUN state.

Behaviour:
- Reset (asynchronous assert, synchronous release) forces:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - sum = 0, cout = 0.
  - counter, carry FF and shift registers = 0.
- States: IDLE, RUN, DONE. Encoding is free; no other states are reachable.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: latch a into shA; latch b (or ~b if sub) into shB; carry = sub; counter = 0; go to RUN.
- RUN:
  - in_ready = 0, busy = 1. in_valid and operand changes are ignored.
  - Each edge:
    - bit = shA[0] ^ shB[0] ^ carry.
    - carry <= (shA[0]&shB[0]) | (carry&(shA[0]^shB[0])).
    - Result register shifts right, bit entering the MSB.
    - shA and shB shift right.
    - counter increments.
  - At the edge where counter == WIDTH-1: the last bit is shifted in, cout <= new carry, go to DONE.
- DONE:
  - out_valid = 1; sum and cout are stable and held.
  - On out_valid & out_ready: go to IDLE, out_valid drops at that edge.
  - Operands are not accepted in the same cycle as the output handshake (in_ready is still 0 in DONE).
- Latency: out_valid rises exactly WIDTH edges after the input-accept edge.
- Throughput: one operation per WIDTH+2 cycles at best (accept, WIDTH bits, out handshake, return to IDLE).
- Output timing:
  - sum and cout may change during RUN (shift register visible). Consumers sample only when out_valid is high.
  - sum and cout hold their last value in IDLE until the next RUN begins.
- Boundaries:
  - Backpressure (out_ready low) holds DONE indefinitely with outputs unchanged.
  - out_ready high while not in DONE has no effect.
  - Reset asserted mid-RUN or in DONE aborts immediately to reset values; no partial result is ever flagged valid.
  - Sub with a == b gives sum 0, cout 1.
  - Overflow wraps modulo 2^WIDTH; carry is reported only via cout.

Test Plan:
- WIDTH=8, add 8'hFF + 8'h01 -> out_valid high 8 edges after accept; sum=8'h00, cout=1.
- Add 8'h5A + 8'h33 -> sum=8'h8D, cout=0. Sub 8'h05 - 8'h07 -> sum=8'hFE, cout=0. Sub 8'h07 - 8'h05 -> sum=8'h02, cout=1.
- Hold out_ready low 5 cycles in DONE -> out_valid, sum and cout stable; in_ready=0 throughout; a new in_valid is not accepted until after the output handshake and return to IDLE.
- Toggle in_valid, a and b randomly during RUN -> result reflects only the operands latched at accept.
- Assert rst_n low at bit 4 of RUN -> all outputs go to reset values asynchronously; after release the next operation (8'h10 + 8'h20) gives 8'h30.
- WIDTH=4 instance, add 4'hF + 4'hF -> sum=4'hE, cout=1, out_valid after 4 edges.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract sequencer, LSB first, one bit per clock
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [CNT_W-1:0] cnt;
    logic             carry, p, g, s, c_next;
    // one full-adder cell built from two half adders and a carry OR
    always_comb begin
        p      = sh_a[0] ^ sh_b[0];
        g      = sh_a[0] & sh_b[0];
        s      = p ^ carry;
        c_next = g | (p & carry);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            sh_a      <= '0;
            sh_b      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sh_a     <= a;
                    sh_b     <= sub ? ~b : b;
                    carry    <= sub;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    sum   <= {s, sum[WIDTH-1:1]};
                    sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
                    carry <= c_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cout      <= c_next;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
